// File: rtl/regbank16_we_mux_pkg.sv
// Shared constants for the 16-entry register bank with PC shadow in entry 15.
package regbank16_we_mux_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned REG_COUNT      = 16;
    localparam int unsigned ADDR_W         = 4;
    localparam int unsigned PC_REG         = 15;
    localparam int unsigned GROUP_COUNT    = 4;
    localparam int unsigned GROUP_SIZE     = 4;

endpackage

// File: rtl/regbank16_we_mux_mux4.sv
// DATA_W-wide 4:1 multiplexer; sel 00/01/10/11 picks d0/d1/d2/d3.
module regbank16_we_mux_mux4 #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y_c
);

    always_comb begin
        y_c = d0;
        case (sel)
            2'b00:   y_c = d0;
            2'b01:   y_c = d1;
            2'b10:   y_c = d2;
            default: y_c = d3;
        endcase
    end

endmodule

// File: rtl/regbank16_we_mux.sv
// 16x DATA_W register bank: one write port, two combinational read ports,
// entry 15 reloaded from r15_in every cycle and never written via the write port.
module regbank16_we_mux
    import regbank16_we_mux_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] r15_in,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0]    regs [REG_COUNT];
    logic [DATA_W-1:0]    din  [REG_COUNT];
    logic [REG_COUNT-1:0] en;

    // Write decode; entry 15 always loads r15_in, so a3=15 writes are dropped.
    always_comb begin
        en = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            din[i] = wd3;
        end
        for (int unsigned i = 0; i < PC_REG; i++) begin
            en[i] = we3 && (a3 == ADDR_W'(i));
        end
        en[PC_REG]  = 1'b1;
        din[PC_REG] = r15_in;
    end

    // Enable-gated storage; reset wins over any load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (en[i]) begin
                    regs[i] <= din[i];
                end
            end
        end
    end

    logic [DATA_W-1:0] grp1 [GROUP_COUNT];
    logic [DATA_W-1:0] grp2 [GROUP_COUNT];

    // First level: select within each group of four using addr[1:0].
    for (genvar g = 0; g < GROUP_COUNT; g++) begin : g_level1
        regbank16_we_mux_mux4 #(.W(DATA_W)) u_mux_p1 (
            .d0  (regs[g*GROUP_SIZE + 0]),
            .d1  (regs[g*GROUP_SIZE + 1]),
            .d2  (regs[g*GROUP_SIZE + 2]),
            .d3  (regs[g*GROUP_SIZE + 3]),
            .sel (a1[1:0]),
            .y_c (grp1[g])
        );
        regbank16_we_mux_mux4 #(.W(DATA_W)) u_mux_p2 (
            .d0  (regs[g*GROUP_SIZE + 0]),
            .d1  (regs[g*GROUP_SIZE + 1]),
            .d2  (regs[g*GROUP_SIZE + 2]),
            .d3  (regs[g*GROUP_SIZE + 3]),
            .sel (a2[1:0]),
            .y_c (grp2[g])
        );
    end

    // Second level: select the group using addr[3:2].
    regbank16_we_mux_mux4 #(.W(DATA_W)) u_mux_top_p1 (
        .d0  (grp1[0]),
        .d1  (grp1[1]),
        .d2  (grp1[2]),
        .d3  (grp1[3]),
        .sel (a1[3:2]),
        .y_c (rd1)
    );

    regbank16_we_mux_mux4 #(.W(DATA_W)) u_mux_top_p2 (
        .d0  (grp2[0]),
        .d1  (grp2[1]),
        .d2  (grp2[2]),
        .d3  (grp2[3]),
        .sel (a2[3:2]),
        .y_c (rd2)
    );

endmodule

// File: tb/tb_regbank16_we_mux.sv
// Directed, table-driven bench for regbank16_we_mux.
module tb_regbank16_we_mux;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic [31:0] r15_in;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int checks;
    int errors;

    regbank16_we_mux #(.DATA_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .we3    (we3),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .wd3    (wd3),
        .r15_in (r15_in),
        .rd1    (rd1),
        .rd2    (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs applied for one cycle; e1/e2 are the reads expected before that cycle's edge.
    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  a3;
        logic [31:0] wd;
        logic [31:0] r15;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rst, input logic we,
                                input logic [3:0] va1, input logic [3:0] va2,
                                input logic [3:0] va3, input logic [31:0] wd,
                                input logic [31:0] r15, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v.rst = rst; v.we = we; v.a1 = va1; v.a2 = va2; v.a3 = va3;
        v.wd = wd; v.r15 = r15; v.e1 = e1; v.e2 = e2;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reads right after reset: everything zero.
        for (int i = 0; i < 16; i++)
            add(1'b0, 1'b0, 4'(i), 4'(15 - i), 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Write sweep; a2 reads the entry being written (old value), a1 the previous write.
        for (int i = 0; i < 15; i++)
            add(1'b0, 1'b1, (i == 0) ? 4'd0 : 4'(i - 1), 4'(i), 4'(i),
                32'h1000_0000 + 32'(i), 32'h0,
                (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i - 1), 32'h0);

        // Read-back sweep with we3=0 aimed at entry 5.
        for (int i = 0; i < 15; i++)
            add(1'b0, 1'b0, 4'(i), 4'(14 - i), 4'd5, 32'hFFFF_FFFF, 32'h0,
                32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(14 - i));
        add(1'b0, 1'b0, 4'd5, 4'd15, 4'd5, 32'hFFFF_FFFF, 32'h0, 32'h1000_0005, 32'h0);

        // Write to 15 ignored; R15 tracks r15_in with one cycle latency.
        add(1'b0, 1'b1, 4'd0, 4'd1, 4'd15, 32'hAAAA_5555, 32'h40, 32'h1000_0000, 32'h1000_0001);
        add(1'b0, 1'b0, 4'd15, 4'd15, 4'd0, 32'h0, 32'd8, 32'h40, 32'h40);
        add(1'b0, 1'b0, 4'd3, 4'd15, 4'd0, 32'h0, 32'd12, 32'h1000_0003, 32'd8);
        add(1'b0, 1'b0, 4'd14, 4'd15, 4'd0, 32'h0, 32'd16, 32'h1000_000E, 32'd12);
        add(1'b0, 1'b0, 4'd15, 4'd15, 4'd0, 32'h0, 32'd16, 32'd16, 32'd16);

        // Read-during-write: old value before the edge, new value after.
        add(1'b0, 1'b1, 4'd7, 4'd7, 4'd7, 32'h1234_5678, 32'd16, 32'h1000_0007, 32'h1000_0007);
        add(1'b0, 1'b0, 4'd7, 4'd7, 4'd0, 32'h0, 32'd16, 32'h1234_5678, 32'h1234_5678);

        // Mid-run reset with a simultaneous write to 2 and R15 load.
        add(1'b1, 1'b1, 4'd2, 4'd15, 4'd2, 32'h0000_0055, 32'h99, 32'h1000_0002, 32'd16);
        for (int i = 0; i < 16; i++)
            add(1'b0, 1'b0, 4'(i), 4'(15 - i), 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Initial reset held two edges with a competing write and R15 load.
        reset  = 1'b1;
        we3    = 1'b1;
        a1     = 4'd3;
        a2     = 4'd15;
        a3     = 4'd3;
        wd3    = 32'hDEAD_BEEF;
        r15_in = 32'h100;
        repeat (2) @(posedge clk);

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            reset  = vq[k].rst;
            we3    = vq[k].we;
            a1     = vq[k].a1;
            a2     = vq[k].a2;
            a3     = vq[k].a3;
            wd3    = vq[k].wd;
            r15_in = vq[k].r15;
            #1;
            check("rd1", k, rd1, vq[k].e1);
            check("rd2", k, rd2, vq[k].e2);
        end

        // Hand sequence: same-address write/read observed just after the edge.
        @(negedge clk);
        reset  = 1'b0;
        we3    = 1'b1;
        a1     = 4'd9;
        a2     = 4'd9;
        a3     = 4'd9;
        wd3    = 32'hCAFE_F00D;
        r15_in = 32'h0;
        #1;
        check("rdw_pre_rd1", 0, rd1, 32'h0);
        @(posedge clk);
        #1;
        check("rdw_post_rd1", 0, rd1, 32'hCAFE_F00D);
        check("rdw_post_rd2", 0, rd2, 32'hCAFE_F00D);
        we3 = 1'b0;

        // Hand sequence: single-cycle reset pulse clears the freshly written entry.
        @(negedge clk);
        reset = 1'b1;
        we3   = 1'b1;
        a3    = 4'd9;
        wd3   = 32'h1111_2222;
        @(posedge clk);
        #1;
        check("rst_pulse_rd1", 0, rd1, 32'h0);
        reset = 1'b0;
        we3   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank16_we_mux.md
Name: regbank16_we_mux

Overview:
- 16-entry × 32-bit register bank with two combinational read ports and one synchronous write port.
- Built from enable-gated registers and two-level 4:1 mux trees.
- Entry 15 is a program-counter shadow: it is loaded from a dedicated input every cycle and is never written through the write port.
- Sits in the single-cycle datapath between decode (register addresses) and ALU/operand selection.

Parameters:
- DATA_W, 32, width of every register, write data, R15 input and read data.
- Register count is fixed at 16 and address width at 4. The mux tree is fixed at 4×4 and is not parameterised.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all 16 registers.
- we3  in  1  write enable for the write port.
- a1  in  4  read address, port 1.
- a2  in  4  read address, port 2.
- a3  in  4  write address.
- wd3  in  DATA_W  write data.
- r15_in  in  DATA_W  value loaded into entry 15 every cycle (PC+8 from datapath).
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.

Behaviour:
- Storage element, each entry, on rising clk:
  - if reset: entry <= 0
  - else if its enable is 1: entry <= data input
  - else: hold
  - Reset has priority over enable.
- Write decode:
  - enable[i] = we3 AND (a3 == i), for i = 0..14.
  - At most one of entries 0..14 is written per cycle.
  - we3=0 writes nothing.
- Entry 15:
  - enable is tied to 1 and its data input is r15_in, so it loads r15_in on every non-reset edge.
  - A write with a3=15 and we3=1 is ignored (no entry changes).
  - Reset clears entry 15 to 0 like all others.
- Read ports: purely combinational, zero latency.
  - First level: four 4:1 muxes per port select within groups {0-3}, {4-7}, {8-11}, {12-15} using addr[1:0].
  - Second level: a 4:1 mux selects the group using addr[3:2].
- 4:1 mux select encoding: 00 → input 1, 01 → input 2, 10 → input 3, 11 → input 4.
- Both read ports are independent. a1 == a2 is legal and gives identical data.
- Read-during-write to the same address returns the old (pre-edge) value. There is no write-to-read bypass; the new value appears after the edge.
- Entry 15 as read returns the value of r15_in captured at the previous edge (one-cycle latency from r15_in to rd).
- After reset deasserts, all reads return 0 until written (entry 15 until the next edge).
- Reset asserted mid-operation: on that edge every entry goes to 0, and any simultaneous write or R15 load is discarded.
- No X propagation: outputs are always driven; all addresses are decoded.

Decomposition:
- Shared package: DATA_W default (32), REG_COUNT (16), ADDR_W (4), PC_REG index constant (15).
- Sub-module mux4 (DATA_W-wide 4:1 mux, 2-bit select), instantiated 10 times.
- Storage is a per-entry enable register (en_reg), instantiated 16 times. It may be written inline instead if preferred.

Test Plan:
- Reset: assert reset 2 cycles with we3=1, a3=3, wd3=0xDEADBEEF, r15_in=0x100 → all 16 reads (sweep a1, a2 over 0..15) return 0 after the reset edges.
- Write/read sweep: for i=0..14 write wd3=0x1000_0000+i at a3=i → next cycle rd1 at a1=i equals 0x1000_0000+i; rd2 over all other addresses is unchanged.
- Write gating: we3=0, a3=5, wd3=0xFFFFFFFF → entry 5 keeps prior value 0x10000005. Also we3=1, a3=15, wd3=0xAAAA5555, r15_in=0x00000040 → rd1 at a1=15 reads 0x00000040, not 0xAAAA5555.
- R15 tracking: drive r15_in = 8, 12, 16 on successive cycles → rd2 at a2=15 shows 8, 12, 16, each one cycle after presentation.
- Read-during-write: a1=a3=7, we3=1, wd3=0x12345678, old entry 7 = 0x10000007 → before the edge rd1 = 0x10000007; after the edge rd1 = 0x12345678. Simultaneously a2=7 gives identical data.
- Mid-run reset: entries loaded as above, assert reset for one edge with we3=1, a3=2 → every entry including 15 reads 0, and the write to 2 is lost.
